// File: rtl/sha512_stream_hasher.sv
// Streaming multi-message SHA-512 front end.
// sha512_core: iterative SHA-512 compression engine, one round per clock.
// sha512_stream_hasher: buffers pre-padded blocks in a small FIFO, sequences
// init/next per message and hands back a truncated, tagged digest.

module sha512_core (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          init,
   input  logic          next,
   input  logic [1:0]    mode,
   input  logic [1023:0] block,
   output logic          ready,
   output logic [511:0]  digest
);

   localparam logic [63:0] K [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [511:0] iv_for(input logic [1:0] m);
      case (m)
         2'd0:    return {64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
                          64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};
         2'd1:    return {64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
                          64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};
         2'd2:    return {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
                          64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
         default: return {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                          64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
      endcase
   endfunction

   logic [63:0]  h_q [8];
   logic [63:0]  h_d [8];
   logic [63:0]  work_q [8];
   logic [63:0]  work_d [8];
   logic [63:0]  w_q [16];
   logic [63:0]  w_d [16];
   logic [6:0]   round_q, round_d;
   logic         running_q, running_d;
   logic         ready_q, ready_d;
   logic [63:0]  t1, t2, w_next;
   logic [511:0] iv;

   assign iv     = iv_for(mode);
   assign ready  = ready_q;
   assign digest = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

   // One compression round plus the message-schedule word sixteen rounds ahead
   always_comb begin
      t1 = work_q[7] + (rotr(work_q[4], 14) ^ rotr(work_q[4], 18) ^ rotr(work_q[4], 41))
         + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6])) + K[round_q] + w_q[0];
      t2 = (rotr(work_q[0], 28) ^ rotr(work_q[0], 34) ^ rotr(work_q[0], 39))
         + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));
      w_next = (rotr(w_q[14], 19) ^ rotr(w_q[14], 61) ^ (w_q[14] >> 6)) + w_q[9]
             + (rotr(w_q[1], 1) ^ rotr(w_q[1], 8) ^ (w_q[1] >> 7)) + w_q[0];
   end

   // Start a block on init/next, step rounds, fold the result into H after round 79
   always_comb begin
      h_d       = h_q;
      work_d    = work_q;
      w_d       = w_q;
      round_d   = round_q;
      running_d = running_q;
      ready_d   = ready_q;
      if (ready_q && (init || next)) begin
         for (int i = 0; i < 8; i++) begin
            work_d[i] = init ? iv[511 - 64 * i -: 64] : h_q[i];
            if (init) h_d[i] = iv[511 - 64 * i -: 64];
         end
         for (int i = 0; i < 16; i++) w_d[i] = block[1023 - 64 * i -: 64];
         round_d   = 7'd0;
         running_d = 1'b1;
         ready_d   = 1'b0;
      end else if (running_q) begin
         work_d[0] = t1 + t2;
         work_d[1] = work_q[0];
         work_d[2] = work_q[1];
         work_d[3] = work_q[2];
         work_d[4] = work_q[3] + t1;
         work_d[5] = work_q[4];
         work_d[6] = work_q[5];
         work_d[7] = work_q[6];
         for (int i = 0; i < 15; i++) w_d[i] = w_q[i + 1];
         w_d[15] = w_next;
         round_d = round_q + 7'd1;
         if (round_q == 7'd79) begin
            running_d = 1'b0;
            ready_d   = 1'b1;
            for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + work_d[i];
         end
      end
   end

   // Core state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) begin
            h_q[i]    <= '0;
            work_q[i] <= '0;
         end
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
         round_q   <= '0;
         running_q <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         h_q       <= h_d;
         work_q    <= work_d;
         w_q       <= w_d;
         round_q   <= round_d;
         running_q <= running_d;
         ready_q   <= ready_d;
      end
   end

endmodule

module sha512_stream_hasher #(
   parameter int DEPTH = 2,
   parameter int TAG_W = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1023:0]    in_block,
   input  logic             in_last,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [511:0]     out_digest,
   output logic [1:0]       out_mode,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNT_W-1:0] msg_count
);

   localparam int ENTRY_W = 1024 + 1 + 2 + TAG_W;
   localparam int PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DELIVER} state_t;

   state_t state_q, state_d;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;
   logic               in_ready_q, in_ready_d;

   logic [1023:0]      blk_q, blk_d;
   logic               last_q, last_d;
   logic [1:0]         msg_mode_q, msg_mode_d;
   logic [TAG_W-1:0]   msg_tag_q, msg_tag_d;
   logic               first_block_q, first_block_d;
   logic [511:0]       out_digest_q, out_digest_d;
   logic [1:0]         out_mode_q, out_mode_d;
   logic [TAG_W-1:0]   out_tag_q, out_tag_d;
   logic               out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   msg_count_q, msg_count_d;

   logic               push, pop, core_init, core_next, clear_first, load_out, out_fire;
   logic               core_ready;
   logic [511:0]       core_digest, masked_digest;
   logic [ENTRY_W-1:0] head;

   assign push     = in_valid && in_ready_q;
   assign out_fire = out_valid_q && out_ready;
   assign head     = mem_q[rd_ptr_q];

   sha512_core u_core (
      .clk     (clk),
      .reset_n (!reset),
      .init    (core_init),
      .next    (core_next),
      .mode    (msg_mode_q),
      .block   (blk_q),
      .ready   (core_ready),
      .digest  (core_digest)
   );

   // Zero the digest bits that the selected truncated variant does not return
   always_comb begin
      case (msg_mode_q)
         2'd0:    masked_digest = core_digest & {{224{1'b1}}, {288{1'b0}}};
         2'd1:    masked_digest = core_digest & {{256{1'b1}}, {256{1'b0}}};
         2'd2:    masked_digest = core_digest & {{384{1'b1}}, {128{1'b0}}};
         default: masked_digest = core_digest;
      endcase
   end

   // Block FIFO: write on push, advance on pop, ready tracks next-cycle occupancy
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {in_block, in_last, in_mode, in_tag};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      in_ready_d = (count_d != CNT_FULL);
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state: pop, issue, see the core go busy, see it finish, deliver
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (count_q != '0 && core_ready) state_d = ISSUE;
         ISSUE:     if (core_ready) state_d = WAIT_ACK;
         WAIT_ACK:  if (!core_ready) state_d = WAIT_DONE;
         WAIT_DONE: if (core_ready) state_d = last_q ? DELIVER : IDLE;
         DELIVER:   if (!out_valid_q || out_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // FSM outputs: FIFO pop, core strobes, message-boundary and digest-load controls
   always_comb begin
      pop         = 1'b0;
      core_init   = 1'b0;
      core_next   = 1'b0;
      clear_first = 1'b0;
      load_out    = 1'b0;
      case (state_q)
         IDLE:      pop = (count_q != '0) && core_ready;
         ISSUE: begin
            core_init = core_ready && first_block_q;
            core_next = core_ready && !first_block_q;
         end
         WAIT_DONE: clear_first = core_ready && !last_q;
         DELIVER:   load_out = !out_valid_q || out_ready;
         default:   ;
      endcase
   end

   // Datapath: latch the popped block, track message context, manage the output slot
   always_comb begin
      blk_d         = blk_q;
      last_d        = last_q;
      msg_mode_d    = msg_mode_q;
      msg_tag_d     = msg_tag_q;
      first_block_d = first_block_q;
      out_digest_d  = out_digest_q;
      out_mode_d    = out_mode_q;
      out_tag_d     = out_tag_q;
      out_valid_d   = out_valid_q;
      msg_count_d   = msg_count_q;
      if (pop) begin
         blk_d  = head[ENTRY_W-1 -: 1024];
         last_d = head[TAG_W + 2];
         if (first_block_q) begin
            msg_mode_d = head[TAG_W + 1 -: 2];
            msg_tag_d  = head[TAG_W-1:0];
         end
      end
      if (clear_first) first_block_d = 1'b0;
      if (out_fire) begin
         out_valid_d = 1'b0;
         msg_count_d = msg_count_q + CNT_W'(1);
      end
      if (load_out) begin
         out_digest_d  = masked_digest;
         out_mode_d    = msg_mode_q;
         out_tag_d     = msg_tag_q;
         out_valid_d   = 1'b1;
         first_block_d = 1'b1;
      end
   end

   // Datapath and FIFO registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         in_ready_q    <= 1'b1;
         blk_q         <= '0;
         last_q        <= 1'b0;
         msg_mode_q    <= 2'd0;
         msg_tag_q     <= '0;
         first_block_q <= 1'b1;
         out_digest_q  <= '0;
         out_mode_q    <= 2'd0;
         out_tag_q     <= '0;
         out_valid_q   <= 1'b0;
         msg_count_q   <= '0;
      end else begin
         mem_q         <= mem_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         in_ready_q    <= in_ready_d;
         blk_q         <= blk_d;
         last_q        <= last_d;
         msg_mode_q    <= msg_mode_d;
         msg_tag_q     <= msg_tag_d;
         first_block_q <= first_block_d;
         out_digest_q  <= out_digest_d;
         out_mode_q    <= out_mode_d;
         out_tag_q     <= out_tag_d;
         out_valid_q   <= out_valid_d;
         msg_count_q   <= msg_count_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_digest = out_digest_q;
   assign out_mode   = out_mode_q;
   assign out_tag    = out_tag_q;
   assign out_valid  = out_valid_q;
   assign msg_count  = msg_count_q;
   assign busy       = (count_q != '0) || (state_q != IDLE) || out_valid_q;

endmodule

// File: tb/tb_sha512_stream_hasher.sv
// Self-checking bench for sha512_stream_hasher using known SHA-512 family vectors.

module tb_sha512_stream_hasher;

   localparam logic [1023:0] ABC_BLK = {24'h616263, 8'h80, 864'h0, 128'd24};
   localparam logic [511:0] ABC512 = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
   localparam logic [511:0] ABC384 = {384'hcb00753f45a35e8bb5a03d699ac65007272c32ab0eded1631a8b605a43ff5bed8086072ba1e7cc2358baeca134c825a7, 128'h0};
   localparam logic [511:0] ABC256 = {256'h53048e2681941ef99b2e29b76b4c7dabe4c2d0c634fc6d46e0e2f13107e7af23, 256'h0};
   localparam logic [511:0] ABC224 = {224'h4634270f707b6a54daae7530460842e20e37ed265ceee9a43e8924aa, 288'h0};
   localparam logic [511:0] TWO512 = 512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909;

   logic          clk, reset;
   logic [1023:0] in_block;
   logic          in_last, in_valid, out_ready;
   logic [1:0]    in_mode;
   logic [7:0]    in_tag;
   logic          in_ready, out_valid, busy;
   logic [511:0]  out_digest;
   logic [1:0]    out_mode;
   logic [7:0]    out_tag;
   logic [31:0]   msg_count;
   logic          in_ready2, out_valid2, busy2;
   logic [511:0]  out_digest2;
   logic [1:0]    out_mode2;
   logic [7:0]    out_tag2;
   logic [3:0]    msg_count2;

   int tests = 0;
   int failed = 0;
   int init_cnt = 0;
   int next_cnt = 0;

   typedef struct {
      logic [1023:0] blk;
      logic [1:0]    mode;
      logic [7:0]    tag;
      logic [511:0]  exp_digest;
   } vec_t;

   vec_t vecs [4];

   sha512_stream_hasher #(.DEPTH(2), .TAG_W(8), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .in_block(in_block), .in_last(in_last), .in_mode(in_mode),
      .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready), .out_digest(out_digest),
      .out_mode(out_mode), .out_tag(out_tag), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .msg_count(msg_count)
   );

   sha512_stream_hasher #(.DEPTH(2), .TAG_W(8), .CNT_W(4)) dut_wrap (
      .clk(clk), .reset(reset), .in_block(in_block), .in_last(in_last), .in_mode(in_mode),
      .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready2), .out_digest(out_digest2),
      .out_mode(out_mode2), .out_tag(out_tag2), .out_valid(out_valid2), .out_ready(out_ready),
      .busy(busy2), .msg_count(msg_count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count core strobes so init/next usage per message can be checked
   always @(posedge clk) begin
      if (dut.core_init) init_cnt <= init_cnt + 1;
      if (dut.core_next) next_cnt <= next_cnt + 1;
   end

   // Hard stop in case something wedges beyond every bounded wait
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic check_output(input string name, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic note_timeout(input string name);
      tests++;
      failed++;
      $display("[TB] FAIL %s: timed out", name);
   endtask

   task automatic apply_stimulus(input logic [1023:0] b, input logic l, input logic [1:0] m, input logic [7:0] t);
      int n;
      n = 0;
      in_block = b;
      in_last  = l;
      in_mode  = m;
      in_tag   = t;
      in_valid = 1'b1;
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) note_timeout("push");
      else @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output logic ok);
      int n;
      n = 0;
      while (!out_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      ok = out_valid;
      if (!ok) note_timeout("out_valid");
   endtask

   task automatic get_output(output logic [511:0] d, output logic [1:0] m, output logic [7:0] t);
      logic ok;
      wait_valid(ok);
      d = out_digest;
      m = out_mode;
      t = out_tag;
      if (ok) begin
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [511:0] d, held_d;
   logic [1:0]   m;
   logic [7:0]   t;
   logic         ok;
   int           i0, n0, cnt;
   logic [895:0] msg2;

   initial begin
      msg2 = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
      vecs[0] = '{ABC_BLK, 2'd3, 8'h11, ABC512};
      vecs[1] = '{ABC_BLK, 2'd2, 8'h12, ABC384};
      vecs[2] = '{ABC_BLK, 2'd1, 8'h13, ABC256};
      vecs[3] = '{ABC_BLK, 2'd0, 8'h14, ABC224};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_block = '0; in_last = 1'b0; in_mode = 2'd0; in_tag = 8'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check_output("reset in_ready", in_ready, 1);
      check_output("reset out_valid", out_valid, 0);
      check_output("reset out_digest", out_digest, 0);
      check_output("reset busy", busy, 0);
      check_output("reset msg_count", msg_count, 0);
      check_output("reset2 in_ready", in_ready2, 1);
      check_output("reset2 out_valid", out_valid2, 0);
      check_output("reset2 out_digest", out_digest2, 0);
      check_output("reset2 out_mode", {out_mode2, out_tag2}, 0);
      check_output("reset2 busy", busy2, 0);
      check_output("reset2 msg_count", msg_count2, 0);

      // single-block messages across all four modes
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(vecs[k].blk, 1'b1, vecs[k].mode, vecs[k].tag);
         get_output(d, m, t);
         check_output($sformatf("vec%0d digest", k), d, vecs[k].exp_digest);
         check_output($sformatf("vec%0d mode", k), m, vecs[k].mode);
         check_output($sformatf("vec%0d tag", k), t, vecs[k].tag);
         check_output($sformatf("vec%0d msg_count", k), msg_count, k + 1);
      end

      // two-block message; the second block's mode and tag must be ignored
      i0 = init_cnt; n0 = next_cnt;
      apply_stimulus({msg2, 8'h80, 120'h0}, 1'b0, 2'd3, 8'h22);
      apply_stimulus({1008'h0, 16'h0380}, 1'b1, 2'd0, 8'h99);
      get_output(d, m, t);
      check_output("two-block digest", d, TWO512);
      check_output("two-block mode", m, 3);
      check_output("two-block tag", t, 8'h22);
      check_output("two-block init count", init_cnt - i0, 1);
      check_output("two-block next count", next_cnt - n0, 1);

      // back-to-back messages with the output stalled
      pulse_reset();
      apply_stimulus(ABC_BLK, 1'b1, 2'd3, 8'h01);
      apply_stimulus(ABC_BLK, 1'b1, 2'd3, 8'h02);
      apply_stimulus(ABC_BLK, 1'b1, 2'd3, 8'h03);
      check_output("b2b in_ready full", in_ready, 0);
      check_output("b2b busy", busy, 1);
      wait_valid(ok);
      held_d = out_digest;
      repeat (200) @(negedge clk);
      check_output("b2b held valid", out_valid, 1);
      check_output("b2b held tag", out_tag, 8'h01);
      check_output("b2b held digest", out_digest, held_d);
      for (int k = 1; k <= 3; k++) begin
         get_output(d, m, t);
         check_output($sformatf("b2b tag %0d", k), t, k);
         check_output($sformatf("b2b digest %0d", k), d, ABC512);
      end
      check_output("b2b msg_count", msg_count, 3);

      // reset in the middle of a two-block message with a digest pending
      apply_stimulus(ABC_BLK, 1'b1, 2'd3, 8'h55);
      wait_valid(ok);
      apply_stimulus({msg2, 8'h80, 120'h0}, 1'b0, 2'd3, 8'h44);
      cnt = 0;
      while (dut.core_ready && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      if (dut.core_ready) note_timeout("core busy");
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_output("async in_ready", in_ready, 1);
      check_output("async out_valid", out_valid, 0);
      check_output("async out_digest", out_digest, 0);
      check_output("async out_mode/tag", {out_mode, out_tag}, 0);
      check_output("async busy", busy, 0);
      check_output("async msg_count", msg_count, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      i0 = init_cnt; n0 = next_cnt;
      apply_stimulus(ABC_BLK, 1'b1, 2'd3, 8'h66);
      get_output(d, m, t);
      check_output("post-reset digest", d, ABC512);
      check_output("post-reset tag", t, 8'h66);
      check_output("post-reset init count", init_cnt - i0, 1);
      check_output("post-reset next count", next_cnt - n0, 0);

      // counter wrap on the 4-bit instance
      pulse_reset();
      for (int k = 0; k < 17; k++) begin
         apply_stimulus(ABC_BLK, 1'b1, 2'd3, k[7:0]);
         get_output(d, m, t);
      end
      check_output("wrap last tag", t, 8'd16);
      check_output("wrap msg_count 4-bit", msg_count2, 1);
      check_output("wrap msg_count 32-bit", msg_count, 17);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
